instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: turns RV32I instruction descriptors into 32-bit words and writes them to instruction memory.
// Build macro INSTR_ENC_RANGE_CHECK_EN replaces out-of-range immediates with NOP and raises err.
module instr_encoder #(
  parameter int DEPTH    = 256,
  parameter int ADDR_W   = 8,
  parameter int PAD_NOPS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_fmt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic              in_alt,
  input  logic [31:0]       in_imm,
  input  logic              finish,
  output logic              mem_we,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              done,
  output logic              err
);
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int          CNT_W = ADDR_W + 1;
  localparam int          PAD_W = $clog2(PAD_NOPS + 2);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(DEPTH - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WRITE = 3'd1;
  localparam logic [2:0] PAD   = 3'd2;
  localparam logic [2:0] FULL  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]       state;
  logic [PAD_W-1:0] pad_left;
  logic [31:0]      enc_word;
  logic             enc_illegal;
  logic             enc_fault;
  logic             is_shift;
  logic             last_slot;

  assign is_shift  = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);
  assign last_slot = (count == LAST_C);

  always_comb begin
    enc_word    = NOP;
    enc_illegal = 1'b0;
    case (in_fmt)
      4'd0: enc_word = {1'b0, in_alt, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
      4'd1: begin
        if (is_shift)
          enc_word = {1'b0, in_alt, 5'b0, in_imm[4:0], in_rs1, in_funct3, in_rd, 7'b0010011};
        else
          enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
      end
      4'd2: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
      4'd3: enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
      4'd4: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                        in_imm[4:1], in_imm[11], 7'b1100011};
      4'd5: enc_word = {in_imm[31:12], in_rd, 7'b0110111};
      4'd6: enc_word = {in_imm[31:12], in_rd, 7'b0010111};
      4'd7: enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
      4'd8: enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b1100111};
      default: enc_illegal = 1'b1;
    endcase
  end

`ifdef INSTR_ENC_RANGE_CHECK_EN
  // An immediate fits N signed bits when all bits from N-1 upward agree.
  logic fits12, fits13, fits21, range_bad;
  assign fits12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign fits13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
  assign fits21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

  always_comb begin
    range_bad = 1'b0;
    case (in_fmt)
      4'd1:             range_bad = !fits12 || (is_shift && (in_imm[11:5] != 7'd0));
      4'd2, 4'd3, 4'd8: range_bad = !fits12;
      4'd4:             range_bad = !fits13 || in_imm[0];
      4'd5, 4'd6:       range_bad = (in_imm[11:0] != 12'd0);
      4'd7:             range_bad = !fits21 || in_imm[0];
      default:          range_bad = 1'b0;
    endcase
  end
  assign enc_fault = enc_illegal | range_bad;
`else
  assign enc_fault = enc_illegal;
`endif

  assign in_ready = !rst && (state == IDLE) && (count < DEPTH_C);
  assign mem_we   = (state == WRITE) || (state == PAD);
  assign full     = (state == FULL);
  assign done     = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_addr  <= '0;
      mem_wdata <= NOP;
      count     <= '0;
      err       <= 1'b0;
      pad_left  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && (count < DEPTH_C)) begin
            mem_wdata <= enc_fault ? NOP : enc_word;
            err       <= err | enc_fault;
            state     <= WRITE;
          end else if (finish) begin
            mem_wdata <= NOP;
            pad_left  <= PAD_W'(PAD_NOPS);
            state     <= (PAD_NOPS == 0) ? DONE : PAD;
          end
        end
        WRITE: begin
          if (mem_ack) begin
            count <= count + CNT_W'(1);
            if (!last_slot) mem_addr <= mem_addr + ADDR_W'(1);
            state <= last_slot ? FULL : IDLE;
          end
        end
        PAD: begin
          if (mem_ack) begin
            count    <= count + CNT_W'(1);
            pad_left <= pad_left - PAD_W'(1);
            if (!last_slot) mem_addr <= mem_addr + ADDR_W'(1);
            if (last_slot || (pad_left == PAD_W'(1))) state <= DONE;
          end
        end
        FULL: begin
          if (finish) state <= DONE;
        end
        default: ;
      endcase
    end
  end
endmodule
